// File: rtl/mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// mux_nto1_rr
//   N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.
//   The source is picked either by an explicit select (mode=0) or by
//   round-robin arbitration among valid channels (mode=1). The winner's word
//   is captured in a single output register, sustaining one word per cycle.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_data    N*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid   N, channel i presents data
//   in_ready   N, channel i transfer accepted this cycle (one-hot or zero)
//   mode       0 = explicit select, 1 = round-robin
//   sel        channel index used when mode=0 (values >= N never grant)
//   out_data   registered selected word
//   out_valid  out_data holds a word
//   out_ready  downstream accepts
//   out_src    index of the channel that produced out_data
// -----------------------------------------------------------------------------
module mux_nto1_rr #(
   parameter  int WIDTH = 64,
   parameter  int N     = 4,
   localparam int SELW  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_src
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [SELW-1:0]  src_q,  src_d;
   logic [SELW-1:0]  ptr_q,  ptr_d;
   logic             valid_q, valid_d;

   logic             load_en;
   logic             grant_vld;
   logic [SELW-1:0]  grant_idx;
   logic             xfer;

   // Output register can take a word when empty or draining this cycle.
   assign load_en = !valid_q || out_ready;

   // Grant selection. Explicit select compares against every legal index, so
   // an out-of-range sel simply matches nothing.
   always_comb begin
      int idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               grant_vld = 1'b1;
               grant_idx = SELW'(i);
            end
         end
      end else begin
         // Scan ptr, ptr+1, ... wrapping modulo N; first valid channel wins.
         for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_vld && in_valid[idx[SELW-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = idx[SELW-1:0];
            end
         end
      end
   end

   // No handshake may complete while reset is held, even though the empty
   // output register would otherwise report load_en.
   assign xfer = reset_n && load_en && grant_vld;

   always_comb begin
      for (int i = 0; i < N; i++)
         in_ready[i] = xfer && (grant_idx == SELW'(i));
   end

   always_comb begin
      data_d  = data_q;
      src_d   = src_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      if (xfer) begin
         for (int i = 0; i < N; i++)
            if (grant_idx == SELW'(i)) data_d = in_data[i*WIDTH +: WIDTH];
         src_d   = grant_idx;
         valid_d = 1'b1;
         if (mode)
            ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
      end else if (out_ready) begin
         // Drain with nothing to replace it: data and source are kept.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_src   = src_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_nto1_rr.sv
// -----------------------------------------------------------------------------
// tb_mux_nto1_rr
//   Directed bench for mux_nto1_rr. A 4-channel/64-bit instance is checked
//   every cycle against a behavioural model plus literal expectations; a
//   3-channel/8-bit instance covers the non-power-of-two select and wrap.
// -----------------------------------------------------------------------------
module tb_mux_nto1_rr;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- N=4, WIDTH=64 instance ----------------
   logic [4*64-1:0] in_data4 = '0;
   logic [3:0]      in_valid4 = '0;
   logic [3:0]      in_ready4;
   logic            mode4 = 1'b0;
   logic [1:0]      sel4 = '0;
   logic [63:0]     out_data4;
   logic            out_valid4;
   logic            out_ready4 = 1'b0;
   logic [1:0]      out_src4;

   mux_nto1_rr #(.WIDTH(64), .N(4)) dut4 (
      .clk(clk), .reset_n(reset_n),
      .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
      .mode(mode4), .sel(sel4),
      .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
      .out_src(out_src4)
   );

   // ---------------- N=3, WIDTH=8 instance ----------------
   logic [3*8-1:0] in_data3 = '0;
   logic [2:0]     in_valid3 = '0;
   logic [2:0]     in_ready3;
   logic           mode3 = 1'b0;
   logic [1:0]     sel3 = '0;
   logic [7:0]     out_data3;
   logic           out_valid3;
   logic           out_ready3 = 1'b0;
   logic [1:0]     out_src3;

   mux_nto1_rr #(.WIDTH(8), .N(3)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3),
      .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
      .out_src(out_src3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model of the N=4 instance ----------------
   logic        m_valid = 1'b0;
   logic [63:0] m_data = '0;
   int          m_src = 0;
   int          m_ptr = 0;

   // Winning channel or -1 when nobody may be granted.
   function automatic int m_grant();
      if (!mode4) return (in_valid4[sel4]) ? int'(sel4) : -1;
      for (int k = 0; k < 4; k++)
         if (in_valid4[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] m_ready();
      int g;
      g = m_grant();
      if (!reset_n || (m_valid && !out_ready4) || g < 0) return 4'b0;
      return 4'(1 << g);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      end else if (m_ready() != 4'b0) begin
         int g;
         g = m_grant();
         m_data  = in_data4[g*64 +: 64];
         m_src   = g;
         m_valid = 1'b1;
         if (mode4) m_ptr = (g + 1) % 4;
      end else if (out_ready4) begin
         m_valid = 1'b0;
      end
   end

   // Inputs change just after the rising edge, so the falling edge sees both
   // the settled registered outputs and the combinational in_ready.
   always @(negedge clk) begin
      check("model in_ready",  64'(in_ready4),  64'(m_ready()));
      check("model out_valid", 64'(out_valid4), 64'(m_valid));
      check("model out_data",  out_data4,       m_data);
      check("model out_src",   64'(out_src4),   64'(m_src));
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic fill4_const();
      for (int i = 0; i < 4; i++) in_data4[i*64 +: 64] = 64'(i + 1);
   endtask

   // {mode, sel[1:0], valid[3:0], out_ready}
   logic [7:0] vec [16] = '{
      8'b1_00_1111_1, 8'b1_00_0110_1, 8'b1_00_0110_0, 8'b1_00_0110_1,
      8'b0_01_0010_1, 8'b0_11_0111_1, 8'b0_11_1000_0, 8'b0_11_1000_1,
      8'b1_10_0101_1, 8'b1_10_0101_1, 8'b1_00_0000_1, 8'b1_00_1010_0,
      8'b0_00_0001_1, 8'b1_00_1100_1, 8'b1_00_1100_1, 8'b1_00_1111_1
   };

   initial begin
      // ---- reset state ----
      step(); step();
      check("reset in_ready",  64'(in_ready4),  64'h0);
      check("reset out_valid", 64'(out_valid4), 64'h0);
      check("reset out_data",  out_data4,       64'h0);
      check("reset out_src",   64'(out_src4),   64'h0);
      reset_n = 1'b1;

      // ---- explicit select ----
      mode4 = 1'b0; sel4 = 2'd2; in_valid4 = 4'b1111; out_ready4 = 1'b1;
      fill4_const();
      in_data4[2*64 +: 64] = 64'hA5A5;
      @(negedge clk);
      check("sel2 in_ready", 64'(in_ready4), 64'h4);
      step();
      check("sel2 out_data",  out_data4,       64'hA5A5);
      check("sel2 out_src",   64'(out_src4),   64'd2);
      check("sel2 out_valid", 64'(out_valid4), 64'd1);
      in_valid4 = 4'b1011;
      @(negedge clk);
      check("sel2 invalid in_ready", 64'(in_ready4), 64'h0);
      step();
      check("sel2 invalid drain",    64'(out_valid4), 64'd0);
      check("drain holds data",      out_data4,       64'hA5A5);

      // ---- round-robin rotation ----
      fill4_const();
      mode4 = 1'b1; in_valid4 = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr out_src",  64'(out_src4),  64'(k % 4));
         check("rr out_data", out_data4,      64'(k % 4 + 1));
      end
      step();                              // grant 0, pointer moves to 1
      check("rr ptr->1 src", 64'(out_src4), 64'd0);
      in_valid4 = 4'b1001;
      step();
      check("rr skip to 3", 64'(out_src4), 64'd3);
      step();
      check("rr wrap to 0", 64'(out_src4), 64'd0);

      // ---- back-pressure: pointer is 1 here ----
      in_valid4 = 4'b1111; out_ready4 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall in_ready", 64'(in_ready4), 64'h0);
         step();
         check("stall out_src",  64'(out_src4),  64'd0);
         check("stall out_data", out_data4,      64'd1);
         check("stall valid",    64'(out_valid4), 64'd1);
      end
      out_ready4 = 1'b1;
      @(negedge clk);
      check("unstall in_ready", 64'(in_ready4), 64'h2);
      step();
      check("no bubble src",   64'(out_src4),   64'd1);
      check("no bubble data",  out_data4,       64'd2);
      check("no bubble valid", 64'(out_valid4), 64'd1);

      // ---- drain only ----
      in_valid4 = 4'b0000;
      step();
      check("drain valid", 64'(out_valid4), 64'd0);
      check("drain data",  out_data4,       64'd2);

      // ---- mode change keeps pointer (now 2) ----
      mode4 = 1'b0; sel4 = 2'd3; in_valid4 = 4'b1111;
      step();
      check("sel3 src", 64'(out_src4), 64'd3);
      mode4 = 1'b1;
      step();
      check("rr after sel src", 64'(out_src4), 64'd2);

      // ---- vector table, model checked every cycle ----
      for (int v = 0; v < 16; v++) begin
         {mode4, sel4, in_valid4, out_ready4} = vec[v];
         for (int i = 0; i < 4; i++) in_data4[i*64 +: 64] = {32'(v), 32'(i)};
         step();
      end

      // ---- reset mid-stream ----
      mode4 = 1'b1; in_valid4 = 4'b1111; out_ready4 = 1'b1;
      step();
      #2 reset_n = 1'b0;
      #1;
      check("async rst valid",    64'(out_valid4), 64'd0);
      check("async rst data",     out_data4,       64'd0);
      check("async rst src",      64'(out_src4),   64'd0);
      check("async rst in_ready", 64'(in_ready4),  64'h0);
      step();
      reset_n = 1'b1;
      fill4_const();
      step();
      check("post rst first grant", 64'(out_src4), 64'd0);
      check("post rst valid",       64'(out_valid4), 64'd1);
      in_valid4 = 4'b0000;

      // ---- N=3: out-of-range select, then wrap ----
      for (int i = 0; i < 3; i++) in_data3[i*8 +: 8] = 8'(8'h10 + i);
      mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("n3 sel3 in_ready", 64'(in_ready3), 64'h0);
         step();
         check("n3 sel3 valid", 64'(out_valid3), 64'd0);
      end
      mode3 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("n3 rr src",  64'(out_src3),  64'(k % 3));
         check("n3 rr data", 64'(out_data3), 64'(8'h10 + k % 3));
      end
      in_valid3 = 3'b000;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
